// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32/64 M-extension unit, radix-2 shift-add multiply and restoring divide.
module rv_muldiv_iter #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_res,
    output logic            o_valid,
    output logic            o_busy,
    output logic            o_stall
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t            state;
    logic [1:0]        f3;
    logic              s1, s2;
    logic [XLEN-1:0]   ma, mb;
    logic [2*XLEN-1:0] p;
    logic [CW-1:0]     cnt;
    logic              in_s1, in_s2, n1, n2, dz, ovf;
    logic [XLEN-1:0]   in_ma, in_mb, spec_res, fres, mres, quo, rem, dres;
    logic [2*XLEN-1:0] fprod, fsigned, mul_nxt, prod, div_nxt;
    logic [XLEN:0]     sum, rs, diff;
    assign in_s1    = i_f3[2] ? ~i_f3[0] : (i_f3[1:0] == 2'b01 || i_f3[1:0] == 2'b10);
    assign in_s2    = i_f3[2] ? ~i_f3[0] : (i_f3[1:0] == 2'b01);
    assign n1       = in_s1 & i_rs1[XLEN-1];
    assign n2       = in_s2 & i_rs2[XLEN-1];
    assign in_ma    = n1 ? -i_rs1 : i_rs1;
    assign in_mb    = n2 ? -i_rs2 : i_rs2;
    assign dz       = i_rs2 == '0;
    assign ovf      = in_s2 && i_rs1 == {1'b1, {(XLEN-1){1'b0}}} && &i_rs2;
    assign spec_res = dz ? (i_f3[1] ? i_rs1 : '1) : (i_f3[1] ? '0 : i_rs1);
    assign fprod    = {{XLEN{1'b0}}, in_ma} * {{XLEN{1'b0}}, in_mb};
    assign fsigned  = (n1 ^ n2) ? -fprod : fprod;
    assign fres     = i_f3[1:0] == 2'b00 ? fsigned[XLEN-1:0] : fsigned[2*XLEN-1:XLEN];
    // Multiply: upper half accumulates, lower half shifts out multiplier bits as product bits shift in.
    assign sum      = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, ma} : '0);
    assign mul_nxt  = {sum, p[XLEN-1:1]};
    assign prod     = (s1 ^ s2) ? -mul_nxt : mul_nxt;
    assign mres     = f3 == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    // Divide: upper half is the partial remainder, lower half turns from dividend into quotient.
    assign rs       = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    assign diff     = rs - {1'b0, mb};
    assign div_nxt  = {diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0], p[XLEN-2:0], ~diff[XLEN]};
    assign quo      = (s1 ^ s2) ? -p[XLEN-1:0] : p[XLEN-1:0];
    assign rem      = s1 ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    assign dres     = f3[1] ? rem : quo;
    assign o_busy   = state != IDLE;
    assign o_stall  = i_valid & ~o_valid & ~i_flush;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_res   <= '0;
            f3      <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            ma      <= '0;
            mb      <= '0;
            p       <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        f3  <= i_f3[1:0];
                        s1  <= n1;
                        s2  <= n2;
                        ma  <= in_ma;
                        mb  <= in_mb;
                        cnt <= '0;
                        if (!i_f3[2] && FAST_MUL) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_res   <= fres;
                        end else if (i_f3[2] && (dz || ovf)) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_res   <= spec_res;
                        end else if (!i_f3[2]) begin
                            state <= MUL;
                            p     <= {{XLEN{1'b0}}, in_mb};
                        end else begin
                            state <= DIV;
                            p     <= {{XLEN{1'b0}}, in_ma};
                        end
                    end
                end
                MUL: begin
                    p   <= mul_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_res   <= mres;
                    end
                end
                DIV: begin
                    p   <= div_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    state   <= DONE;
                    o_valid <= 1'b1;
                    o_res   <= dres;
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/rv_muldiv_iter.md
RV_MULDIV_ITER -- requirements
Module: rv_muldiv_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (8..64, power of two).
REQ-002 SHALL have parameter FAST_MUL, default 0: 1 = single-cycle multiply, 0 = radix-2 iterative multiply.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  M-extension instruction present in execute stage.
REQ-006 SHALL have port i_f3  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports i_rs1, i_rs2  input  XLEN  operands.
REQ-008 SHALL have port i_flush  input  1  abort current operation.
REQ-009 SHALL have port o_res  output  XLEN  result.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse, o_res valid.
REQ-011 SHALL have port o_busy  output  1  state not IDLE.
REQ-012 SHALL have port o_stall  output  1  pipeline hold request.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-014 In IDLE with i_valid=1 and i_flush=0, SHALL register i_rs1, i_rs2, i_f3 and operand signs at the clock edge.
REQ-015 From IDLE, SHALL go to DONE for FAST_MUL=1 multiplies and divide special cases, to MUL for FAST_MUL=0 multiplies, to DIV otherwise.
REQ-016 MUL SHALL run exactly XLEN iterations on magnitudes (2*XLEN-bit product), then go to DONE; the iteration counter is $clog2(XLEN)+1 bits wide.
REQ-017 DIV SHALL run exactly XLEN restoring-division iterations on magnitudes, then go to FIX; FIX applies the signs, then goes to DONE.
REQ-018 Sign rules: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU/DIVU/REMU unsigned; quotient negated when operand signs differ; remainder takes the dividend sign.
REQ-019 Result selection: MUL = product[XLEN-1:0]; MULH* = product[2*XLEN-1:XLEN].
REQ-020 Divide by zero SHALL give DIV/DIVU = all-ones and REM/REMU = rs1.
REQ-021 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL give DIV = rs1 and REM = 0.
REQ-022 Latency, counted from the IDLE sampling edge (cycle 0) to o_valid=1:
- FAST_MUL or special case: cycle 1.
- Iterative MUL: cycle XLEN+1.
- DIV/REM: cycle XLEN+2.
REQ-023 In DONE, SHALL drive o_valid=1 and update o_res, then go to IDLE unconditionally; o_res holds its value until the next DONE.
REQ-024 o_stall SHALL be (i_valid AND NOT o_valid AND NOT i_flush); it is low in the DONE cycle so the pipeline advances.
REQ-025 i_valid held high after DONE SHALL be treated as a new instruction, accepted in the following IDLE cycle (minimum one-cycle gap).
REQ-026 i_flush SHALL force IDLE at the next edge from any state, suppress o_valid, leave o_res unchanged, and take priority over i_valid in IDLE.
REQ-027 Operand changes on i_rs1/i_rs2/i_f3 after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-028 i_rst=0 SHALL immediately, without a clock, force state IDLE, counter 0, o_valid 0, o_busy 0, o_res 0, and clear internal registers.
REQ-029 Reset asserted mid-operation SHALL discard that operation; no o_valid follows deassertion.

Verification (XLEN=32, FAST_MUL=0 unless stated)
REQ-030 MUL 7 x 0xFFFFFFFD -> o_res 0xFFFFFFEB, o_valid at cycle 33, o_stall high in cycles 0-32 and low in cycle 33.
REQ-031 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- FAST_MUL=1 gives the same values at cycle 1.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, both at cycle 34; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 Special cases, each with o_valid at cycle 1:
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 i_flush at cycle 10 of a DIV -> no o_valid, o_busy 0 at cycle 11, o_res unchanged; next MUL 3x4 -> 12 with correct latency.
REQ-035 i_rst low at cycle 15 of a MUL -> o_busy, o_valid, o_res all 0 before the next edge; no o_valid after release; next op correct.
